// File: rtl/status_pkg.sv
// Shared types for the status reporter: event levels, the log entry layout
// and the payload used for watchdog timeout events.
package status_pkg;

   typedef enum logic [1:0] {
      INFO    = 2'd0,
      ERROR   = 2'd1,
      FATAL   = 2'd2,
      SUCCESS = 2'd3
   } level_t;

   localparam logic [15:0] TIMEOUT_CODE = 16'hDEAD;

   typedef struct packed {
      level_t      level;
      logic [15:0] code;
   } log_evt_t;

endpackage

// File: rtl/status_fifo.sv
// First-word-fall-through event FIFO; DEPTH must be a power of two so the
// pointers wrap naturally, and a write while full is allowed only with a pop.
module status_fifo
   import status_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  log_evt_t                     din_i,
   output log_evt_t                     dout_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   log_evt_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            wr_en, rd_en;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din_i;
   end

   // Head is masked while empty so stale storage never reaches the log port.
   always_comb begin
      dout_o = '0;
      if (!empty_o) dout_o = mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/status_reporter.sv
// Event reporter: core events and watchdog timeouts are queued for the log
// port; a FATAL entry halts intake. STATUS_REPORTER_DROP_EN drops on full.
module status_reporter
   import status_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        evt_valid,
   output logic        evt_ready,
   input  logic [1:0]  evt_level,
   input  logic [15:0] evt_code,
   input  logic        heartbeat,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [1:0]  log_level,
   output logic [15:0] log_code,
   output logic        halted,
   output logic [7:0]  drop_cnt
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_TERM = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {RUN, HALT} state_t;

   state_t          state_q;
   logic            halted_q;
   logic            pending_q, pending_d;
   logic [WDW-1:0]  wd_q, wd_d;

   log_evt_t        fifo_din, fifo_dout;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;

   logic            run, ready_int, core_accept, core_push, core_fatal;
   logic            pend_push, go_halt, wd_term;

   assign run         = (state_q == RUN);
   assign fifo_pop    = !fifo_empty && log_ready;
   assign core_accept = evt_valid && ready_int;
   assign core_fatal  = core_accept && (evt_level == FATAL);
   assign pend_push   = pending_q && ((fifo_count != CW'(DEPTH)) || fifo_pop);
   assign go_halt     = run && (pend_push || core_fatal);
   assign wd_term     = (wd_q == WD_TERM) && !heartbeat;

`ifdef STATUS_REPORTER_DROP_EN
   logic [7:0] drop_q, drop_d;

   assign ready_int = !rst && run && !pending_q;
   assign core_push = core_accept && !fifo_full;

   always_comb begin
      drop_d = drop_q;
      if (core_accept && fifo_full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`else
   assign ready_int = !rst && run && !pending_q && !fifo_full;
   assign core_push = core_accept;
   assign drop_cnt  = '0;
`endif

   assign evt_ready = ready_int;
   assign fifo_push = core_push || pend_push;

   // The timeout entry and a core entry never coincide: intake is closed while pending.
   always_comb begin
      fifo_din = '{level: level_t'(evt_level), code: evt_code};
      if (pend_push) fifo_din = '{level: FATAL, code: TIMEOUT_CODE};
   end

   // Watchdog is frozen once halted and held while a timeout waits for a slot.
   always_comb begin
      wd_d      = wd_q;
      pending_d = pending_q;
      if (run) begin
         if (heartbeat)          wd_d = '0;
         else if (pending_q)     wd_d = wd_q;
         else if (wd_q == WD_TERM) wd_d = '0;
         else                    wd_d = wd_q + WDW'(1);

         if (pend_push)                             pending_d = 1'b0;
         else if (!pending_q && wd_term && !core_fatal) pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q      <= '0;
         pending_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (go_halt) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end
            end
            HALT:    halted_q <= 1'b1;
            default: begin
               state_q  <= RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign halted = halted_q;

   status_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign log_valid = !fifo_empty;
   assign log_level = fifo_dout.level;
   assign log_code  = fifo_dout.code;

endmodule

// File: tb/tb_status_reporter.sv
// Self-checking bench for status_reporter: queue-based reference model plus
// directed scenarios and randomized traffic.
module tb_status_reporter;
   import status_pkg::*;

   localparam int DEPTH = 4;
   localparam int TO    = 1000;
`ifdef STATUS_REPORTER_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        evt_valid = 1'b0;
   logic        evt_ready;
   logic [1:0]  evt_level = 2'd0;
   logic [15:0] evt_code = 16'd0;
   logic        heartbeat = 1'b0;
   logic        log_valid;
   logic        log_ready = 1'b0;
   logic [1:0]  log_level;
   logic [15:0] log_code;
   logic        halted;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   status_reporter #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_level (evt_level),
      .evt_code  (evt_code),
      .heartbeat (heartbeat),
      .log_valid (log_valid),
      .log_ready (log_ready),
      .log_level (log_level),
      .log_code  (log_code),
      .halted    (halted),
      .drop_cnt  (drop_cnt)
   );

   typedef struct {
      logic [1:0]  lvl;
      logic [15:0] code;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] obs[$];
   bit          m_halted, m_pending;
   int          m_idle, m_drop;
   int          dead_seen;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_halted  = 1'b0;
      m_pending = 1'b0;
      m_idle    = 0;
      m_drop    = 0;
   endtask

   function automatic bit m_ready();
      return !m_halted && !m_pending && (DROP || mq.size() < DEPTH);
   endfunction

   // One clock cycle: compare at the falling edge, then advance the model
   // with the inputs that the coming rising edge will capture.
   task automatic step();
      ent_t e;
      bit full, pop, acc, pend_push, was_halted, pend_before, core_fatal, fire;
      @(negedge clk);
      chk("log_valid", log_valid, mq.size() > 0);
      chk("log_level", log_level, mq.size() > 0 ? mq[0].lvl : 2'd0);
      chk("log_code",  log_code,  mq.size() > 0 ? mq[0].code : 16'd0);
      chk("evt_ready", evt_ready, m_ready());
      chk("halted",    halted,    m_halted);
      chk("drop_cnt",  drop_cnt,  m_drop);
      if (log_valid && log_ready) begin
         obs.push_back(log_code);
         if (log_code == 16'hDEAD && log_level == 2'd2) dead_seen++;
      end

      full        = (mq.size() == DEPTH);
      pop         = (mq.size() > 0) && log_ready;
      acc         = evt_valid && m_ready();
      was_halted  = m_halted;
      pend_before = m_pending;
      pend_push   = pend_before && (!full || pop);
      core_fatal  = acc && (evt_level == 2'd2);
      // The TO-th consecutive silent cycle raises the timeout.
      fire = !was_halted && !pend_before && !heartbeat && (m_idle + 1 == TO) && !core_fatal;

      if (pop) void'(mq.pop_front());
      if (pend_push) begin
         e.lvl = 2'd2; e.code = 16'hDEAD;
         mq.push_back(e);
         m_halted  = 1'b1;
         m_pending = 1'b0;
      end
      if (acc) begin
         if (full && DROP) begin
            if (m_drop < 255) m_drop++;
         end else begin
            e.lvl = evt_level; e.code = evt_code;
            mq.push_back(e);
         end
         if (core_fatal) m_halted = 1'b1;
      end
      if (!was_halted) begin
         if (heartbeat) m_idle = 0;
         else if (fire) begin
            m_pending = 1'b1;
            m_idle    = 0;
         end else if (!pend_before) m_idle++;
      end
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; asserts reset asynchronously mid-cycle.
   task automatic do_reset();
      rst = 1'b1;
      evt_valid = 1'b0; heartbeat = 1'b0; log_ready = 1'b0;
      #1;
      chk("rst_log_valid", log_valid, 1'b0);
      chk("rst_evt_ready", evt_ready, 1'b0);
      chk("rst_halted",    halted,    1'b0);
      chk("rst_drop_cnt",  drop_cnt,  8'd0);
      chk("rst_log_code",  log_code,  16'd0);
      chk("rst_log_level", log_level, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_evt_ready", evt_ready, 1'b0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic rand_round(input int n, input bit allow_fatal);
      logic [1:0] lv;
      for (int c = 0; c < n; c++) begin
         lv = 2'($urandom_range(0, 3));
         if (lv == 2'd2 && !(allow_fatal && $urandom_range(0, 31) == 0)) lv = 2'd0;
         evt_valid = 1'($urandom_range(0, 1));
         evt_level = lv;
         evt_code  = 16'($urandom);
         log_ready = 1'($urandom_range(0, 1));
         heartbeat = ($urandom_range(0, 7) == 0);
         step();
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Two events in order, each visible one cycle after its push.
      heartbeat = 1'b1; log_ready = 1'b1;
      evt_valid = 1'b1; evt_level = 2'd0; evt_code = 16'h0001;
      step();
      chk("req022_first_valid", log_valid, 1'b1);
      chk("req022_first_code",  log_code,  16'h0001);
      evt_level = 2'd3; evt_code = 16'h0002;
      step();
      chk("req022_second_code",  log_code,  16'h0002);
      chk("req022_second_level", log_level, 2'd3);
      chk("req022_halted",       halted,    1'b0);
      evt_valid = 1'b0;
      repeat (3) step();

      // Fill to DEPTH, then a fifth event against backpressure or drop.
      log_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1; evt_level = 2'd1; evt_code = 16'h0010 + 16'(i);
         step();
      end
      chk("req023_full_ready", evt_ready, DROP);
      evt_code = 16'h0014;
      step();
`ifdef STATUS_REPORTER_DROP_EN
      chk("req023_drop_cnt", drop_cnt, 8'd1);
      evt_valid = 1'b0;
`endif
      log_ready = 1'b1;
      repeat (2) step();
      evt_valid = 1'b0;
      repeat (6) step();

      // Randomized traffic with resets between rounds.
      do_reset();
      rand_round(300, 1'b0);
      do_reset();
      rand_round(300, 1'b0);
      do_reset();
      rand_round(300, 1'b1);

      // Timeout with no heartbeat: one DEAD entry, halted after the push.
      do_reset();
      dead_seen = 0;
      repeat (1000) step();
      chk("req024_pre_halted", halted,    1'b0);
      chk("req024_pre_valid",  log_valid, 1'b0);
      step();
      chk("req024_halted",     halted,    1'b1);
      chk("req024_code",       log_code,  16'hDEAD);
      chk("req024_level",      log_level, 2'd2);
      log_ready = 1'b1;
      repeat (2000) step();
      chk("req024_dead_count", dead_seen, 1);
      chk("req024_still_halted", halted, 1'b1);

      // Heartbeat every 999 cycles keeps the watchdog quiet.
      do_reset();
      dead_seen = 0;
      for (int c = 0; c < 5000; c++) begin
         heartbeat = ((c % 999) == 998);
         evt_valid = ($urandom_range(0, 15) == 0);
         evt_level = 2'd1;
         evt_code  = 16'($urandom_range(0, 255));
         log_ready = 1'b1;
         step();
      end
      chk("req025_halted", halted,    0);
      chk("req025_dead",   dead_seen, 0);

      // Full FIFO at timeout: the pending FATAL takes the first free slot.
      do_reset();
      obs.delete();
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1; evt_level = 2'd0; evt_code = 16'h0020 + 16'(i);
         step();
      end
      evt_level = 2'd1; evt_code = 16'h0055;
      repeat (1000) step();
      chk("req026_evt_ready", evt_ready, 1'b0);
      chk("req026_not_halted", halted, 1'b0);
      log_ready = 1'b1;
      repeat (8) step();
      chk("req026_pop_count", obs.size(), DROP ? 5 : 5);
      if (obs.size() >= 5) begin
         chk("req026_fourth", obs[3], 16'h0023);
         chk("req026_fatal",  obs[4], 16'hDEAD);
      end
      chk("req026_halted", halted, 1'b1);
      evt_valid = 1'b0;

      // Reset mid-drain with three entries queued.
      do_reset();
      heartbeat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1; evt_level = 2'd3; evt_code = 16'h0030 + 16'(i);
         step();
      end
      evt_valid = 1'b0; log_ready = 1'b1;
      step();
      chk("req027_before_valid", log_valid, 1'b1);
      chk("req027_before_code",  log_code,  16'h0031);
      do_reset();
      chk("req027_after_valid",  log_valid, 1'b0);
      chk("req027_after_halted", halted,    1'b0);
      repeat (1000) step();
      chk("req027_wd_pre_valid", log_valid, 1'b0);
      step();
      chk("req027_wd_code",   log_code, 16'hDEAD);
      chk("req027_wd_halted", halted,   1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
